// File: rtl/mem_lsu.sv
// Memory-stage LSU: lane alignment, misalignment faults and a background store buffer; load 1+wait cycles, store/other 1.
// Backpressure: combinational stall on pending load (waitrequest/hazard), full buffer, or fence with stores outstanding.
package mem_lsu_pkg;
    typedef enum logic [1:0] {
        OP_LS_BYTE     = 2'd0,
        OP_LS_HALFWORD = 2'd1,
        OP_LS_WORD     = 2'd2
    } ls_op_t;
endpackage

module mem_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 32,
    parameter int SB_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic                  load_inst,
    input  logic                  store_inst,
    input  logic [1:0]            ls_op,
    input  logic                  ls_sext,
    input  logic                  fence,
    input  logic [ADDR_WIDTH-1:0] agu_result,
    input  logic [31:0]           st_data,
    input  logic [4:0]            dest_reg,
    input  logic                  dest_reg_valid,
    output logic                  cache_rd,
    output logic                  cache_wr,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wr_data,
    output logic [BE_WIDTH-1:0]   cache_wr_be,
    input  logic [DATA_WIDTH-1:0] cache_data,
    input  logic                  cache_waitrequest,
    output logic                  stall,
    output logic [31:0]           result,
    output logic                  result_valid,
    output logic [4:0]            result_reg,
    output logic                  result_reg_valid,
    output logic                  addr_fault,
    output logic                  sb_empty
);
    import mem_lsu_pkg::*;

    localparam int OFF_W  = $clog2(BE_WIDTH);
    localparam int LANE_W = OFF_W + 3;
    localparam int PTR_W  = $clog2(SB_DEPTH);
    localparam int WA_W   = ADDR_WIDTH - OFF_W;
    localparam logic [LANE_W-1:0] TOP_BIT = LANE_W'(DATA_WIDTH - 1);

    logic [OFF_W-1:0]  off, off_h, off_w;
    logic [LANE_W-1:0] b_base, h_base, w_base;
    logic [WA_W-1:0]   word_addr;
    logic              misaligned, load_req, store_req, complete;

    assign off       = agu_result[OFF_W-1:0];
    assign off_h     = off & ~OFF_W'(1);
    assign off_w     = off & ~OFF_W'(3);
    assign b_base    = TOP_BIT - {off, 3'b000};
    assign h_base    = TOP_BIT - {off_h, 3'b000};
    assign w_base    = TOP_BIT - {off_w, 3'b000};
    assign word_addr = agu_result[ADDR_WIDTH-1:OFF_W];

    always_comb begin
        misaligned = 1'b0;
        if (ls_op == OP_LS_HALFWORD)
            misaligned = agu_result[0];
        else if (ls_op != OP_LS_BYTE)
            misaligned = |agu_result[1:0];
    end

    assign load_req  = in_valid && load_inst && !misaligned;
    assign store_req = in_valid && store_inst && !misaligned;

    logic [DATA_WIDTH-1:0] wr_lane;
    logic [BE_WIDTH-1:0]   be_lane;

    always_comb begin
        wr_lane = '0;
        be_lane = '0;
        case (ls_op)
            OP_LS_BYTE: begin
                wr_lane[b_base -: 8]     = st_data[7:0];
                be_lane[BE_WIDTH-1]      = 1'b1;
            end
            OP_LS_HALFWORD: begin
                wr_lane[h_base -: 16]    = st_data[15:0];
                be_lane[BE_WIDTH-1 -: 2] = 2'b11;
            end
            default: begin
                wr_lane[w_base -: 32]    = st_data;
                be_lane[BE_WIDTH-1 -: 4] = 4'hF;
            end
        endcase
        be_lane = be_lane >> off;
    end

    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_w, ld_val;

    assign ld_b = cache_data[b_base -: 8];
    assign ld_h = cache_data[h_base -: 16];
    assign ld_w = cache_data[w_base -: 32];

    always_comb begin
        case (ls_op)
            OP_LS_BYTE:     ld_val = {{24{ls_sext & ld_b[7]}}, ld_b};
            OP_LS_HALFWORD: ld_val = {{16{ls_sext & ld_h[15]}}, ld_h};
            default:        ld_val = ld_w;
        endcase
    end

    logic [WA_W-1:0]       sb_addr [SB_DEPTH];
    logic [DATA_WIDTH-1:0] sb_data [SB_DEPTH];
    logic [BE_WIDTH-1:0]   sb_be   [SB_DEPTH];
    logic [SB_DEPTH-1:0]   sb_vld;
    logic [PTR_W-1:0]      head, tail;
    logic [PTR_W:0]        count;
    logic                  sb_full, wr_held, hazard, enq, deq, load_done;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++)
            if (sb_vld[i] && sb_addr[i] == word_addr)
                hazard = 1'b1;
    end

    assign sb_empty = (count == '0);
    assign sb_full  = (count == (PTR_W + 1)'(SB_DEPTH));

    // A write already stuck behind waitrequest keeps the port; otherwise a clean load wins.
    assign cache_rd      = load_req && !hazard && !wr_held;
    assign cache_wr      = !sb_empty && !cache_rd;
    assign cache_addr    = cache_wr ? {{OFF_W{1'b0}}, sb_addr[head]} : {{OFF_W{1'b0}}, word_addr};
    assign cache_wr_data = sb_data[head];
    assign cache_wr_be   = cache_wr ? sb_be[head] : '0;

    assign load_done = cache_rd && !cache_waitrequest;
    assign deq       = cache_wr && !cache_waitrequest;
    assign stall     = (load_req && !load_done) || (store_req && sb_full) || (fence && !sb_empty);
    assign enq       = store_req && !stall;
    assign complete  = in_valid && !stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            sb_vld  <= '0;
            wr_held <= 1'b0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_addr[i] <= '0;
                sb_data[i] <= '0;
                sb_be[i]   <= '0;
            end
        end else begin
            if (enq) begin
                sb_addr[tail] <= word_addr;
                sb_data[tail] <= wr_lane;
                sb_be[tail]   <= be_lane;
                sb_vld[tail]  <= 1'b1;
                tail          <= tail + 1'b1;
            end
            if (deq) begin
                sb_vld[head] <= 1'b0;
                head         <= head + 1'b1;
            end
            if (enq && !deq)
                count <= count + 1'b1;
            else if (!enq && deq)
                count <= count - 1'b1;
            wr_held <= cache_wr && cache_waitrequest;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result           <= '0;
            result_valid     <= 1'b0;
            result_reg       <= '0;
            result_reg_valid <= 1'b0;
            addr_fault       <= 1'b0;
        end else begin
            result_valid <= complete;
            if (complete) begin
                result           <= load_req ? ld_val : agu_result[31:0];
                result_reg       <= dest_reg;
                result_reg_valid <= dest_reg_valid;
                addr_fault       <= (load_inst || store_inst) && misaligned;
            end
        end
    end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-stage load/store unit with a parametrised cache data path and a store buffer that retires stores in the background. Sits between the EX/MEM pipeline register and the data cache. Handles cache wait states, checks alignment, orders loads against buffered stores, and aligns data for byte, halfword and word accesses. Lanes are big-endian: byte offset 0 is the most-significant byte. The result is registered toward MEM/WB.

## Interface
- DATA_WIDTH, 32: cache data width; 32 or 64.
- BE_WIDTH, DATA_WIDTH/8: cache byte enables.
- ADDR_WIDTH, 32: byte address width.
- SB_DEPTH, 4: store buffer entries; a power of two, at least 2.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present in MEM.
- load_inst, store_inst  in  1 each  access type; never both set.
- ls_op  in  ls_op_t  OP_LS_BYTE / OP_LS_HALFWORD / OP_LS_WORD.
- ls_sext  in  1  sign-extend byte/halfword loads.
- fence  in  1  hold until the store buffer is empty.
- agu_result  in  ADDR_WIDTH  byte address, or pass-through ALU result for non-memory instructions.
- st_data  in  32  store data, already forwarded.
- dest_reg  in  5  destination register.
- dest_reg_valid  in  1  destination is written.
- cache_rd, cache_wr  out  1 each  cache request.
- cache_addr  out  ADDR_WIDTH  word address, equal to byte address >> log2(BE_WIDTH).
- cache_wr_data  out  DATA_WIDTH  lane-aligned store data.
- cache_wr_be  out  BE_WIDTH  byte enables.
- cache_data  in  DATA_WIDTH  read data, valid in the accept cycle.
- cache_waitrequest  in  1  request not accepted this cycle.
- stall  out  1  freeze the stages upstream of MEM; combinational.
- result  out  32  registered load data or pass-through value.
- result_valid  out  1  registered; a valid instruction left MEM.
- result_reg, result_reg_valid  out  5, 1  registered destination.
- addr_fault  out  1  registered; the instruction that just left MEM was misaligned.
- sb_empty  out  1  store buffer has no entries.

## Operation
- **Alignment.** Halfword accesses require agu_result[0]=0. Word accesses require agu_result[1:0]=0.
  - A misaligned access issues no cache request and no enqueue.
  - It completes in one cycle with addr_fault=1.
- **Lane mapping.** Byte offset k is agu_result[log2(BE_WIDTH)-1:0].
  - Byte at offset k: bits [DATA_WIDTH-1-8k -: 8], cache_wr_be bit BE_WIDTH-1-k.
  - Halfword at offset k: 16 bits at [DATA_WIDTH-1-8k -: 16] and 2 byte enables.
  - Word at offset k: 32 bits at [DATA_WIDTH-1-8k -: 32] and 4 byte enables.
  - Unselected be bits are 0.
- **Load data.** Loads zero-extend, or sign-extend when ls_sext=1, into 32 bits.
- **Store buffer.** FIFO of {word address, data, be}.
  - A valid aligned store enqueues in one cycle when the buffer is not full.
  - A store that finds the buffer full stalls. An enqueue is not allowed to use a slot being freed in the same cycle.
  - The head drives cache_wr whenever no load owns the port. It dequeues in a cycle where cache_wr=1 and cache_waitrequest=0.
- **Load hazard.** A load stalls, without issuing, while any valid entry has the same word address as the load.
- **Load issue.** A load without a hazard has priority over draining. Its cache_rd and cache_addr stay stable until cache_waitrequest=0, and it completes in that cycle.
- **Fence.** stall=1 while fence=1 and the buffer is not empty.
- **Non-memory instructions.** Complete in one cycle; result takes agu_result[31:0].
- **Stall terms.** stall is the OR of:
  - a pending load (waitrequest or hazard);
  - a store that finds the buffer full;
  - fence while the buffer is not empty.
- **Register update.** Output registers update only on completion. On a stall cycle or in_valid=0, result_valid=0 the next cycle (a bubble is inserted).

## Timing
- **Reset values.**
  - Registered outputs: result=0, result_valid=0, result_reg=0, result_reg_valid=0, addr_fault=0.
  - Buffer empty: sb_empty=1, cache_rd=cache_wr=0, cache_wr_be=0.
- **Latency.** Load: issue-cycle count is 1 + waitrequest cycles; the result appears the cycle after acceptance. Store: 1 cycle into the buffer. Non-memory instructions: 1 cycle.
- **Pointers and count.** Pointers wrap modulo SB_DEPTH. The count is log2(SB_DEPTH)+1 bits wide.
- **Enqueue and drain together.** Both happen in the same cycle when the buffer is non-full; the count is unchanged.
- **Write held by waitrequest.** Once a write has been presented with waitrequest=1, it stays presented. A newly arriving load waits behind it, keeping the cache request stable.
- **Reset mid-operation.** Asserting reset_n low drops all buffered stores and any pending request immediately.

## Test plan
- **Byte store and load.** DATA_WIDTH=32, empty buffer, SB_DEPTH=4.
  - SB 0xAB to 0x1001 -> cache_wr=1, cache_addr=0x400, cache_wr_be=4'b0100, data bits[23:16]=0xAB.
  - LB from 0x1003 with cache_data=0x000000F0 and ls_sext=1 -> result=0xFFFFFFF0 the next cycle.
- **Waitrequest.** Hold cache_waitrequest=1 for 3 cycles on LW 0x2000.
  - stall=1 for 3 cycles; cache_addr stays 0x800.
  - result_valid pulses once, the cycle after acceptance.
- **Buffer full.** Keep cache_waitrequest=1 and issue 5 stores.
  - The 5th store stalls; sb_empty=0.
  - Release waitrequest -> entries drain in FIFO order, one per cycle; sb_empty=1 after 4 writes.
- **Load hazard.** SW 0x3000 then LW 0x3000 back-to-back, with waitrequest=1 for 2 cycles on the write.
  - The load stalls until the store dequeues.
  - The read returns the stored value.
- **Misalignment.** LH at 0x1001 -> no cache_rd; addr_fault=1 and result_valid=1 the next cycle.
- **DATA_WIDTH=64.** SW to 0x0C -> cache_addr=0x1, cache_wr_be=8'h0F, data in bits[31:0].
- **Reset.** Assert reset with 2 entries buffered -> sb_empty=1 and cache_wr=0 immediately.
